// File: rtl/mux_n_1_rr_pkg.sv
// Shared definitions for the N:1 round-robin output multiplexer.
// Mode encodings and the channel-tag width helper.
package mux_n_1_rr_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int sw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_n_1_rr_if.sv
// Producer/consumer handshake bundle around the N:1 multiplexer.
// The slave side is the multiplexer, the master side drives channels and y_ready.
interface mux_n_1_rr_if
    import mux_n_1_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SW = sw_of(N);

    logic               mode;
    logic [SW-1:0]      s;
    logic [N*WIDTH-1:0] i_data;
    logic [N-1:0]       i_valid;
    logic [N-1:0]       i_ready;
    logic [WIDTH-1:0]   y;
    logic               y_valid;
    logic               y_ready;
    logic [SW-1:0]      y_ch;

    modport slave (
        input  mode, s, i_data, i_valid, y_ready,
        output i_ready, y, y_valid, y_ch
    );

    modport master (
        output mode, s, i_data, i_valid, y_ready,
        input  i_ready, y, y_valid, y_ch
    );

endinterface

// File: rtl/mux_n_1_rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr wins.
// The pointer register is owned by the instantiating module.
module mux_n_1_rr_arbiter
    import mux_n_1_rr_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sw_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        int j;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            // ptr is always < N, so one subtraction is enough to wrap
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            for (int c = 0; c < N; c++) begin
                if (!gnt_vld && (c == j) && req[c]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SW'(c);
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_1_rr.sv
// N:1 data multiplexer, manual or round-robin select, registered output
// with valid/ready on both sides and a source-channel tag per word.
module mux_n_1_rr
    import mux_n_1_rr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_n_1_rr_if.slave  bus
);

    localparam int SW = sw_of(N);

    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SW-1:0]    r_y_ch;
    logic [SW-1:0]    r_ptr;

    logic             w_load_en;
    logic [SW-1:0]    w_rr_idx;
    logic             w_rr_vld;
    logic             w_sel_vld;
    logic [SW-1:0]    w_gnt_idx;
    logic             w_gnt_vld;
    logic [N-1:0]     w_ready;
    logic [WIDTH-1:0] w_data;
    logic             w_xfer;

    mux_n_1_rr_arbiter #(.N(N)) u_arb (
        .req     (bus.i_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_vld (w_rr_vld)
    );

    assign w_load_en = !r_y_valid || bus.y_ready;

    // s values at or above N match no channel and never grant
    always_comb begin
        w_sel_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (bus.s == SW'(k) && bus.i_valid[k]) w_sel_vld = 1'b1;
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        if (bus.mode == MODE_RR) begin
            w_gnt_idx = w_rr_idx;
            w_gnt_vld = w_rr_vld;
        end else begin
            w_gnt_idx = bus.s;
            w_gnt_vld = w_sel_vld;
        end
    end

    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt_idx == SW'(k)) begin
                w_data = bus.i_data[k*WIDTH +: WIDTH];
                if (!rst && w_load_en && w_gnt_vld) w_ready[k] = 1'b1;
            end
        end
    end

    assign w_xfer = |w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_ch    <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_xfer) begin
                r_y       <= w_data;
                r_y_ch    <= w_gnt_idx;
                r_y_valid <= 1'b1;
            end else if (r_y_valid && bus.y_ready) begin
                r_y_valid <= 1'b0;
            end
            if (w_xfer && bus.mode == MODE_RR) begin
                r_ptr <= (w_gnt_idx == SW'(N-1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    assign bus.i_ready = w_ready;
    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
    assign bus.y_ch    = r_y_ch;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Directed vector bench for mux_n_1_rr at N=4 and N=3.
module tb_mux_n_1_rr;
    import mux_n_1_rr_pkg::*;

    typedef struct {
        logic        mode;
        logic [1:0]  s;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        yr;
        logic [3:0]  rdy;
        logic        yv;
        logic [7:0]  y;
        logic [1:0]  ch;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n_1_rr_if #(.WIDTH(8), .N(4)) b4();
    mux_n_1_rr_if #(.WIDTH(8), .N(3)) b3();

    mux_n_1_rr #(.WIDTH(8), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    mux_n_1_rr #(.WIDTH(8), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    int n_chk  = 0;
    int n_fail = 0;
    int n_in[4];
    int n_out[4];
    logic mon_en = 1'b0;

    vec_t v4[24];
    vec_t v3[5];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic m, input logic [1:0] s,
        input logic [3:0] vl, input logic [31:0] d, input logic yr,
        input logic [3:0] rdy, input logic yv, input logic [7:0] y,
        input logic [1:0] ch);
        vec_t v;
        v.mode = m; v.s = s; v.valid = vl; v.data = d; v.yr = yr;
        v.rdy = rdy; v.yv = yv; v.y = y; v.ch = ch;
        return v;
    endfunction

    // Conservation scoreboard for the N=4 instance, keyed by y_ch
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                if (b4.y_valid) n_out[b4.y_ch]++;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (b4.i_valid[k] && b4.i_ready[k]) n_in[k]++;
                if (b4.y_valid && b4.y_ready) n_out[b4.y_ch]++;
            end
        end
    end

    initial begin
        v4[0]  = mk(MODE_SEL, 2, 4'b0100, 32'hD3A5B1A0, 1, 4'b0100, 1, 8'hA5, 2);
        v4[1]  = mk(MODE_SEL, 1, 4'b0100, 32'hD3A5B1A0, 1, 4'b0000, 0, 8'hA5, 2);
        v4[2]  = mk(MODE_SEL, 1, 4'b0100, 32'hD3A5B1A0, 1, 4'b0000, 0, 8'hA5, 2);
        v4[3]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 0);
        v4[4]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b0010, 1, 8'h11, 1);
        v4[5]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h12, 2);
        v4[6]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b1000, 1, 8'h13, 3);
        v4[7]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 0);
        v4[8]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b0010, 1, 8'h11, 1);
        v4[9]  = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h12, 2);
        v4[10] = mk(MODE_RR,  0, 4'b1111, 32'h13121110, 1, 4'b1000, 1, 8'h13, 3);
        v4[11] = mk(MODE_RR,  0, 4'b1010, 32'h23222120, 1, 4'b0010, 1, 8'h21, 1);
        v4[12] = mk(MODE_RR,  0, 4'b1010, 32'h23222120, 1, 4'b1000, 1, 8'h23, 3);
        v4[13] = mk(MODE_RR,  0, 4'b1010, 32'h23222120, 1, 4'b0010, 1, 8'h21, 1);
        v4[14] = mk(MODE_RR,  0, 4'b1010, 32'h23222120, 1, 4'b1000, 1, 8'h23, 3);
        v4[15] = mk(MODE_RR,  0, 4'b0001, 32'h23222120, 1, 4'b0001, 1, 8'h20, 0);
        v4[16] = mk(MODE_SEL, 3, 4'b1111, 32'h33323130, 1, 4'b1000, 1, 8'h33, 3);
        v4[17] = mk(MODE_RR,  0, 4'b1111, 32'h33323130, 1, 4'b0010, 1, 8'h31, 1);
        v4[18] = mk(MODE_RR,  0, 4'b1111, 32'h33323130, 0, 4'b0000, 1, 8'h31, 1);
        v4[19] = mk(MODE_RR,  0, 4'b1111, 32'h33323130, 0, 4'b0000, 1, 8'h31, 1);
        v4[20] = mk(MODE_RR,  0, 4'b1111, 32'h33323130, 0, 4'b0000, 1, 8'h31, 1);
        v4[21] = mk(MODE_RR,  0, 4'b1111, 32'h33323130, 1, 4'b0100, 1, 8'h32, 2);
        v4[22] = mk(MODE_RR,  0, 4'b0000, 32'h33323130, 1, 4'b0000, 0, 8'h32, 2);
        v4[23] = mk(MODE_RR,  0, 4'b0100, 32'h43424140, 0, 4'b0100, 1, 8'h42, 2);

        v3[0] = mk(MODE_SEL, 3, 4'b0111, 32'h00C2C1C0, 1, 4'b0000, 0, 8'h00, 0);
        v3[1] = mk(MODE_RR,  0, 4'b0111, 32'h00C2C1C0, 1, 4'b0001, 1, 8'hC0, 0);
        v3[2] = mk(MODE_RR,  0, 4'b0111, 32'h00C2C1C0, 1, 4'b0010, 1, 8'hC1, 1);
        v3[3] = mk(MODE_RR,  0, 4'b0111, 32'h00C2C1C0, 1, 4'b0100, 1, 8'hC2, 2);
        v3[4] = mk(MODE_RR,  0, 4'b0111, 32'h00C2C1C0, 1, 4'b0001, 1, 8'hC0, 0);

        b4.mode = MODE_SEL; b4.s = '0; b4.i_data = '0;
        b4.i_valid = '0; b4.y_ready = 1'b0;
        b3.mode = MODE_SEL; b3.s = '0; b3.i_data = '0;
        b3.i_valid = '0; b3.y_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", 0, 32'(b4.y), 0);
        chk("rst_yv", 0, 32'(b4.y_valid), 0);
        chk("rst_ych", 0, 32'(b4.y_ch), 0);
        chk("rst_rdy", 0, 32'(b4.i_ready), 0);
        chk("rst_yv3", 0, 32'(b3.y_valid), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 24; i++) begin
            b4.mode = v4[i].mode; b4.s = v4[i].s;
            b4.i_valid = v4[i].valid; b4.i_data = v4[i].data;
            b4.y_ready = v4[i].yr;
            #1;
            chk("rdy4", i, 32'(b4.i_ready), 32'(v4[i].rdy));
            chk("onehot4", i, 32'($countones(b4.i_ready) <= 1), 1);
            @(posedge clk);
            #1;
            chk("yv4", i, 32'(b4.y_valid), 32'(v4[i].yv));
            chk("y4", i, 32'(b4.y), 32'(v4[i].y));
            chk("ych4", i, 32'(b4.y_ch), 32'(v4[i].ch));
        end

        // Reset while a word is held and a transfer would otherwise fire
        b4.mode = MODE_RR; b4.i_valid = 4'b1111;
        b4.i_data = 32'h53525150; b4.y_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", 0, 32'(b4.i_ready), 0);
        @(posedge clk);
        #1;
        chk("rst_mid_y", 0, 32'(b4.y), 0);
        chk("rst_mid_yv", 0, 32'(b4.y_valid), 0);
        chk("rst_mid_ych", 0, 32'(b4.y_ch), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 0, 32'(b4.i_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_y", 0, 32'(b4.y), 32'h50);
        chk("post_rst_ych", 0, 32'(b4.y_ch), 0);
        b4.i_valid = '0; b4.y_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            b3.mode = v3[i].mode; b3.s = v3[i].s;
            b3.i_valid = v3[i].valid[2:0]; b3.i_data = v3[i].data[23:0];
            b3.y_ready = v3[i].yr;
            #1;
            chk("rdy3", i, 32'(b3.i_ready), 32'(v3[i].rdy[2:0]));
            chk("onehot3", i, 32'($countones(b3.i_ready) <= 1), 1);
            @(posedge clk);
            #1;
            chk("yv3", i, 32'(b3.y_valid), 32'(v3[i].yv));
            chk("y3", i, 32'(b3.y), 32'(v3[i].y));
            chk("ych3", i, 32'(b3.y_ch), 32'(v3[i].ch));
        end

        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("sb_words", k,
                32'(n_out[k] + ((b4.y_valid && b4.y_ch == 2'(k)) ? 1 : 0)),
                32'(n_in[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
